decode_issue_stage: RTL and testbench
=====================================

Name: decode_issue_stage

Overview:
Parametrised successor of the RV decode stage. It decodes one instruction per cycle and generates all immediate formats sign-extended to XLEN. It forwards rs1/rs2 from EXE/MEM/WB, detects load-use hazards and inserts bubbles, and registers results into the EXE latch under a valid/ready handshake with flush. The register file sits outside the block and is read combinationally through RS1_ADDR/RS2_ADDR.

Parameters:
XLEN, 64, datapath width; legal values 32 or 64.
MEM_LOAD_FWD, 0, 1 = load data in MEM stage is forwardable; 0 = load must reach WB first.
CNT_W, 16, width of saturating bubble counter.

Ports:
CLK  in  1  clock
RESET  in  1  synchronous, active-high reset
DE_V  in  1  decode-stage instruction valid
DE_IR  in  32  instruction
DE_NPC  in  XLEN  PC+4 of instruction
DE_READY  out  1  decode accepts DE_IR this cycle
RS1_ADDR  out  5  DE_IR[19:15], to register file
RS2_ADDR  out  5  DE_IR[24:20], to register file
RS1_DATA  in  XLEN  register file read data 1
RS2_DATA  in  XLEN  register file read data 2
EXE_FWD_V, EXE_FWD_WE, EXE_FWD_LD  in  1 each  EXE-stage valid / writes rd / is load
EXE_FWD_RD  in  5;  EXE_FWD_DATA  in  XLEN
MEM_FWD_V, MEM_FWD_WE, MEM_FWD_LD  in  1 each;  MEM_FWD_RD  in  5;  MEM_FWD_DATA  in  XLEN
WB_FWD_V, WB_FWD_WE  in  1 each;  WB_FWD_RD  in  5;  WB_FWD_DATA  in  XLEN
FLUSH  in  1  kill decode and EXE latch contents
EXE_READY  in  1  execute stage can accept
EXE_V  out  1  latch valid
EXE_IR  out  32;  EXE_NPC  out  XLEN
EXE_OP1  out  XLEN  ALU operand 1
EXE_OP2  out  XLEN  ALU operand 2
EXE_IMM  out  XLEN  decoded immediate
EXE_STORE_DATA  out  XLEN  forwarded rs2
EXE_ECALL  out  1  DE_IR == 32'h00000073
EXE_ILLEGAL  out  1  unsupported opcode
STALL_CNT  out  CNT_W  saturating count of hazard bubbles

Behaviour:
- Reset: all EXE_* outputs and STALL_CNT = 0 on the first posedge with RESET=1. RESET has priority over FLUSH and the handshake.
- Forwarding, per source operand: x0 always reads 0. Otherwise the youngest matching source wins: EXE > MEM > WB > RSx_DATA.
- A source matches when V & WE & RD == addr & RD != 0.
- An EXE match with EXE_FWD_LD = 1 is a hazard, not a forward.
- A MEM match with MEM_FWD_LD = 1 is a hazard when MEM_LOAD_FWD = 0.
- Hazards count only for operands the opcode actually uses:
  - rs1: all except LUI/AUIPC/JAL.
  - rs2: OP, OP-32, BRANCH, STORE.
- Immediates: I, S, B, U, J formats, sign-extended from IR[31] to XLEN.
  - Shift-immediate shamt: IR[25:20] when XLEN = 64, IR[24:20] when XLEN = 32.
  - OP-IMM-32/OP-32 are illegal when XLEN = 32.
- Operands:
  - OP1: DE_NPC - 4 for AUIPC/JAL; 0 for LUI; fwd rs1 otherwise.
  - OP2: fwd rs2 for OP/OP-32/BRANCH; EXE_IMM otherwise.
  - EXE_STORE_DATA: always fwd rs2.
- Handshake:
  - advance = EXE_READY | !EXE_V.
  - DE_READY = advance & !hazard & !FLUSH.
  - advance & DE_V & !hazard: latch loads, EXE_V = 1.
  - advance & (hazard | !DE_V): EXE_V <= 0 (bubble); other EXE_* hold.
  - !advance: latch holds all values.
- FLUSH: EXE_V <= 0 next edge; overrides hold and load. DE_READY = 0 that cycle.
- Bubble counter: STALL_CNT += 1 on each edge where DE_V & hazard & advance & !FLUSH. It saturates at 2^CNT_W - 1 and never wraps.
- Latency: 1 cycle from DE_READY & DE_V to EXE_V.
- Load-use bubbles:
  - MEM_LOAD_FWD = 1: 1 bubble.
  - MEM_LOAD_FWD = 0: 2 bubbles.
- RESET mid-stall drops the pending instruction and clears the counter.

Test Plan:
- ADD x3,x1,x2 with EXE rd=1 data=5, MEM rd=1 data=7, WB rd=2 data=9 -> EXE_OP1=5, EXE_OP2=9 after 1 cycle.
- LD x5 in EXE (EXE_FWD_LD=1), then ADD x6,x5,x0, MEM_LOAD_FWD=0 -> 2 bubbles (EXE_V=0 twice), DE_READY low 2 cycles, STALL_CNT=2; third cycle issues with WB data.
- Forwarding source with RD=0, data=123 -> operand reads 0, no hazard.
- EXE_READY=0 for 3 cycles with EXE_V=1 -> all EXE_* stable, DE_READY=0. FLUSH on cycle 2 -> EXE_V=0 next edge.
- Immediates: BEQ imm=-8 -> EXE_IMM=all-ones-except-low 3 bits (0x...FFF8). SLLI shamt=40 at XLEN=64 -> EXE_IMM=40. OP-IMM-32 at XLEN=32 -> EXE_ILLEGAL=1. AUIPC 0x80000 at NPC=0x1004 -> EXE_OP1=0x1000, EXE_IMM sign-extended 0xFFFF...80000000.
- CNT_W=2 with 5 hazard bubbles -> STALL_CNT stops at 3. RESET -> 0.

Source files
------------

// File: rtl/decode_issue_stage.sv
// decode_issue_stage: single-issue RISC-V decode stage feeding an EXE latch.
// Decodes one instruction per cycle, builds all immediate formats sign-extended
// to XLEN, forwards rs1/rs2 from EXE/MEM/WB, stalls on load-use hazards and
// registers the decoded result under a valid/ready handshake with flush.
//
// Ports:
//   CLK, RESET                 clock, synchronous active-high reset
//   DE_V/DE_IR/DE_NPC          incoming instruction, valid and PC+4
//   DE_READY                   instruction accepted this cycle (combinational)
//   RS1_ADDR/RS2_ADDR          register file read addresses (combinational)
//   RS1_DATA/RS2_DATA          register file read data
//   EXE_FWD_*/MEM_FWD_*/WB_FWD_* forwarding sources from later stages
//   FLUSH                      kill decode and EXE latch contents
//   EXE_READY                  execute stage can accept
//   EXE_*                      registered EXE latch payload
//   STALL_CNT                  saturating count of hazard bubbles
module decode_issue_stage #(
  parameter int unsigned XLEN         = 64,
  parameter bit          MEM_LOAD_FWD = 1'b0,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             DE_V,
  input  logic [31:0]      DE_IR,
  input  logic [XLEN-1:0]  DE_NPC,
  output logic             DE_READY,
  output logic [4:0]       RS1_ADDR,
  output logic [4:0]       RS2_ADDR,
  input  logic [XLEN-1:0]  RS1_DATA,
  input  logic [XLEN-1:0]  RS2_DATA,
  input  logic             EXE_FWD_V,
  input  logic             EXE_FWD_WE,
  input  logic             EXE_FWD_LD,
  input  logic [4:0]       EXE_FWD_RD,
  input  logic [XLEN-1:0]  EXE_FWD_DATA,
  input  logic             MEM_FWD_V,
  input  logic             MEM_FWD_WE,
  input  logic             MEM_FWD_LD,
  input  logic [4:0]       MEM_FWD_RD,
  input  logic [XLEN-1:0]  MEM_FWD_DATA,
  input  logic             WB_FWD_V,
  input  logic             WB_FWD_WE,
  input  logic [4:0]       WB_FWD_RD,
  input  logic [XLEN-1:0]  WB_FWD_DATA,
  input  logic             FLUSH,
  input  logic             EXE_READY,
  output logic             EXE_V,
  output logic [31:0]      EXE_IR,
  output logic [XLEN-1:0]  EXE_NPC,
  output logic [XLEN-1:0]  EXE_OP1,
  output logic [XLEN-1:0]  EXE_OP2,
  output logic [XLEN-1:0]  EXE_IMM,
  output logic [XLEN-1:0]  EXE_STORE_DATA,
  output logic             EXE_ECALL,
  output logic             EXE_ILLEGAL,
  output logic [CNT_W-1:0] STALL_CNT
);

  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
  localparam logic       IS_RV32       = (XLEN == 32);

  typedef struct packed {
    logic            haz;
    logic [XLEN-1:0] data;
  } opnd_t;

  typedef enum logic [1:0] {OP1_RS1, OP1_PC, OP1_ZERO} op1_sel_e;

  // Flops
  logic             exe_v_q,       exe_v_d;
  logic [31:0]      exe_ir_q,      exe_ir_d;
  logic [XLEN-1:0]  exe_npc_q,     exe_npc_d;
  logic [XLEN-1:0]  exe_op1_q,     exe_op1_d;
  logic [XLEN-1:0]  exe_op2_q,     exe_op2_d;
  logic [XLEN-1:0]  exe_imm_q,     exe_imm_d;
  logic [XLEN-1:0]  exe_sdata_q,   exe_sdata_d;
  logic             exe_ecall_q,   exe_ecall_d;
  logic             exe_illegal_q, exe_illegal_d;
  logic [CNT_W-1:0] stall_cnt_q,   stall_cnt_d;

  // Decode results
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic             use_rs1, use_rs2, op2_is_rs2, illegal;
  op1_sel_e         op1_sel;
  logic [XLEN-1:0]  imm, imm_i, imm_s, imm_b, imm_u, imm_j, shamt_w, shamt_x;
  logic [XLEN-1:0]  op1;
  opnd_t            src_a, src_b;
  logic             hazard, advance;

  // Youngest matching producer wins; a load not yet forwardable is a hazard.
  // An RD of x0 can never match because addr x0 is resolved first.
  function automatic opnd_t fwd_sel(input logic [4:0] addr, input logic [XLEN-1:0] rf_data);
    opnd_t r;
    r.haz  = 1'b0;
    r.data = rf_data;
    if (addr == 5'd0) begin
      r.data = '0;
    end else if (EXE_FWD_V && EXE_FWD_WE && (EXE_FWD_RD == addr)) begin
      if (EXE_FWD_LD) r.haz  = 1'b1;
      else            r.data = EXE_FWD_DATA;
    end else if (MEM_FWD_V && MEM_FWD_WE && (MEM_FWD_RD == addr)) begin
      if (MEM_FWD_LD && !MEM_LOAD_FWD) r.haz  = 1'b1;
      else                             r.data = MEM_FWD_DATA;
    end else if (WB_FWD_V && WB_FWD_WE && (WB_FWD_RD == addr)) begin
      r.data = WB_FWD_DATA;
    end
    return r;
  endfunction

  assign opcode   = DE_IR[6:0];
  assign funct3   = DE_IR[14:12];
  assign RS1_ADDR = DE_IR[19:15];
  assign RS2_ADDR = DE_IR[24:20];

  // Immediate formats, sign-extended from IR[31]
  assign imm_i   = XLEN'($signed(DE_IR[31:20]));
  assign imm_s   = XLEN'($signed({DE_IR[31:25], DE_IR[11:7]}));
  assign imm_b   = XLEN'($signed({DE_IR[31], DE_IR[7], DE_IR[30:25], DE_IR[11:8], 1'b0}));
  assign imm_u   = XLEN'($signed({DE_IR[31:12], 12'b0}));
  assign imm_j   = XLEN'($signed({DE_IR[31], DE_IR[19:12], DE_IR[20], DE_IR[30:21], 1'b0}));
  // Full-width shifts take a 6-bit shamt on RV64; word shifts always 5-bit
  assign shamt_x = IS_RV32 ? XLEN'(DE_IR[24:20]) : XLEN'(DE_IR[25:20]);
  assign shamt_w = XLEN'(DE_IR[24:20]);

  // Opcode decode: operand usage, immediate format, operand selects
  always_comb begin
    use_rs1    = 1'b1;
    use_rs2    = 1'b0;
    op2_is_rs2 = 1'b0;
    illegal    = 1'b0;
    op1_sel    = OP1_RS1;
    imm        = '0;
    unique case (opcode)
      OPC_LUI:       begin use_rs1 = 1'b0; op1_sel = OP1_ZERO; imm = imm_u; end
      OPC_AUIPC:     begin use_rs1 = 1'b0; op1_sel = OP1_PC;   imm = imm_u; end
      OPC_JAL:       begin use_rs1 = 1'b0; op1_sel = OP1_PC;   imm = imm_j; end
      OPC_JALR,
      OPC_LOAD,
      OPC_MISC_MEM,
      OPC_SYSTEM:    imm = imm_i;
      OPC_BRANCH:    begin use_rs2 = 1'b1; op2_is_rs2 = 1'b1; imm = imm_b; end
      OPC_STORE:     begin use_rs2 = 1'b1; imm = imm_s; end
      OPC_OP_IMM:    imm = (funct3 == 3'b001 || funct3 == 3'b101) ? shamt_x : imm_i;
      OPC_OP_IMM_32: begin
        illegal = IS_RV32;
        imm     = (funct3 == 3'b001 || funct3 == 3'b101) ? shamt_w : imm_i;
      end
      OPC_OP:        begin use_rs2 = 1'b1; op2_is_rs2 = 1'b1; end
      OPC_OP_32:     begin use_rs2 = 1'b1; op2_is_rs2 = 1'b1; illegal = IS_RV32; end
      default:       illegal = 1'b1;
    endcase
  end

  // Forwarding, hazard and operand muxing
  always_comb begin
    src_a    = fwd_sel(RS1_ADDR, RS1_DATA);
    src_b    = fwd_sel(RS2_ADDR, RS2_DATA);
    hazard   = (use_rs1 && src_a.haz) || (use_rs2 && src_b.haz);
    advance  = EXE_READY || !exe_v_q;
    DE_READY = advance && !hazard && !FLUSH;
    unique case (op1_sel)
      OP1_PC:   op1 = DE_NPC - XLEN'(4);
      OP1_ZERO: op1 = '0;
      default:  op1 = src_a.data;
    endcase
  end

  // EXE latch next state: flush > load > bubble > hold
  always_comb begin
    exe_v_d       = exe_v_q;
    exe_ir_d      = exe_ir_q;
    exe_npc_d     = exe_npc_q;
    exe_op1_d     = exe_op1_q;
    exe_op2_d     = exe_op2_q;
    exe_imm_d     = exe_imm_q;
    exe_sdata_d   = exe_sdata_q;
    exe_ecall_d   = exe_ecall_q;
    exe_illegal_d = exe_illegal_q;
    stall_cnt_d   = stall_cnt_q;
    if (FLUSH) begin
      exe_v_d = 1'b0;
    end else if (advance) begin
      if (DE_V && !hazard) begin
        exe_v_d       = 1'b1;
        exe_ir_d      = DE_IR;
        exe_npc_d     = DE_NPC;
        exe_op1_d     = op1;
        exe_op2_d     = op2_is_rs2 ? src_b.data : imm;
        exe_imm_d     = imm;
        exe_sdata_d   = src_b.data;
        exe_ecall_d   = (DE_IR == 32'h0000_0073);
        exe_illegal_d = illegal;
      end else begin
        exe_v_d = 1'b0;
      end
      if (DE_V && hazard && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      exe_v_q       <= 1'b0;
      exe_ir_q      <= '0;
      exe_npc_q     <= '0;
      exe_op1_q     <= '0;
      exe_op2_q     <= '0;
      exe_imm_q     <= '0;
      exe_sdata_q   <= '0;
      exe_ecall_q   <= 1'b0;
      exe_illegal_q <= 1'b0;
      stall_cnt_q   <= '0;
    end else begin
      exe_v_q       <= exe_v_d;
      exe_ir_q      <= exe_ir_d;
      exe_npc_q     <= exe_npc_d;
      exe_op1_q     <= exe_op1_d;
      exe_op2_q     <= exe_op2_d;
      exe_imm_q     <= exe_imm_d;
      exe_sdata_q   <= exe_sdata_d;
      exe_ecall_q   <= exe_ecall_d;
      exe_illegal_q <= exe_illegal_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign EXE_V          = exe_v_q;
  assign EXE_IR         = exe_ir_q;
  assign EXE_NPC        = exe_npc_q;
  assign EXE_OP1        = exe_op1_q;
  assign EXE_OP2        = exe_op2_q;
  assign EXE_IMM        = exe_imm_q;
  assign EXE_STORE_DATA = exe_sdata_q;
  assign EXE_ECALL      = exe_ecall_q;
  assign EXE_ILLEGAL    = exe_illegal_q;
  assign STALL_CNT      = stall_cnt_q;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed bench for decode_issue_stage. Two instances share stimulus:
// u64 (XLEN=64, MEM_LOAD_FWD=0, CNT_W=2) and u32 (XLEN=32, MEM_LOAD_FWD=1).
module tb_decode_issue_stage;

  logic        clk = 1'b0;
  logic        rst, de_v, flush, exe_ready;
  logic [31:0] de_ir;
  logic [63:0] de_npc, rs1_data, rs2_data;
  logic        exe_fwd_v, exe_fwd_we, exe_fwd_ld, mem_fwd_v, mem_fwd_we, mem_fwd_ld;
  logic        wb_fwd_v, wb_fwd_we;
  logic [4:0]  exe_fwd_rd, mem_fwd_rd, wb_fwd_rd;
  logic [63:0] exe_fwd_data, mem_fwd_data, wb_fwd_data;

  logic        a_de_ready, a_exe_v, a_ecall, a_ill;
  logic [4:0]  a_rs1_addr, a_rs2_addr;
  logic [31:0] a_exe_ir;
  logic [63:0] a_npc, a_op1, a_op2, a_imm, a_sd;
  logic [1:0]  a_cnt;

  logic        b_de_ready, b_exe_v, b_ecall, b_ill;
  logic [4:0]  b_rs1_addr, b_rs2_addr;
  logic [31:0] b_exe_ir, b_npc, b_op1, b_op2, b_imm, b_sd;
  logic [15:0] b_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  decode_issue_stage #(.XLEN(64), .MEM_LOAD_FWD(1'b0), .CNT_W(2)) u64 (
    .CLK(clk), .RESET(rst), .DE_V(de_v), .DE_IR(de_ir), .DE_NPC(de_npc),
    .DE_READY(a_de_ready), .RS1_ADDR(a_rs1_addr), .RS2_ADDR(a_rs2_addr),
    .RS1_DATA(rs1_data), .RS2_DATA(rs2_data),
    .EXE_FWD_V(exe_fwd_v), .EXE_FWD_WE(exe_fwd_we), .EXE_FWD_LD(exe_fwd_ld),
    .EXE_FWD_RD(exe_fwd_rd), .EXE_FWD_DATA(exe_fwd_data),
    .MEM_FWD_V(mem_fwd_v), .MEM_FWD_WE(mem_fwd_we), .MEM_FWD_LD(mem_fwd_ld),
    .MEM_FWD_RD(mem_fwd_rd), .MEM_FWD_DATA(mem_fwd_data),
    .WB_FWD_V(wb_fwd_v), .WB_FWD_WE(wb_fwd_we), .WB_FWD_RD(wb_fwd_rd),
    .WB_FWD_DATA(wb_fwd_data), .FLUSH(flush), .EXE_READY(exe_ready),
    .EXE_V(a_exe_v), .EXE_IR(a_exe_ir), .EXE_NPC(a_npc), .EXE_OP1(a_op1),
    .EXE_OP2(a_op2), .EXE_IMM(a_imm), .EXE_STORE_DATA(a_sd),
    .EXE_ECALL(a_ecall), .EXE_ILLEGAL(a_ill), .STALL_CNT(a_cnt)
  );

  decode_issue_stage #(.XLEN(32), .MEM_LOAD_FWD(1'b1), .CNT_W(16)) u32 (
    .CLK(clk), .RESET(rst), .DE_V(de_v), .DE_IR(de_ir), .DE_NPC(de_npc[31:0]),
    .DE_READY(b_de_ready), .RS1_ADDR(b_rs1_addr), .RS2_ADDR(b_rs2_addr),
    .RS1_DATA(rs1_data[31:0]), .RS2_DATA(rs2_data[31:0]),
    .EXE_FWD_V(exe_fwd_v), .EXE_FWD_WE(exe_fwd_we), .EXE_FWD_LD(exe_fwd_ld),
    .EXE_FWD_RD(exe_fwd_rd), .EXE_FWD_DATA(exe_fwd_data[31:0]),
    .MEM_FWD_V(mem_fwd_v), .MEM_FWD_WE(mem_fwd_we), .MEM_FWD_LD(mem_fwd_ld),
    .MEM_FWD_RD(mem_fwd_rd), .MEM_FWD_DATA(mem_fwd_data[31:0]),
    .WB_FWD_V(wb_fwd_v), .WB_FWD_WE(wb_fwd_we), .WB_FWD_RD(wb_fwd_rd),
    .WB_FWD_DATA(wb_fwd_data[31:0]), .FLUSH(flush), .EXE_READY(exe_ready),
    .EXE_V(b_exe_v), .EXE_IR(b_exe_ir), .EXE_NPC(b_npc), .EXE_OP1(b_op1),
    .EXE_OP2(b_op2), .EXE_IMM(b_imm), .EXE_STORE_DATA(b_sd),
    .EXE_ECALL(b_ecall), .EXE_ILLEGAL(b_ill), .STALL_CNT(b_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_fwd();
    exe_fwd_v = 0; exe_fwd_we = 0; exe_fwd_ld = 0; exe_fwd_rd = 0; exe_fwd_data = 0;
    mem_fwd_v = 0; mem_fwd_we = 0; mem_fwd_ld = 0; mem_fwd_rd = 0; mem_fwd_data = 0;
    wb_fwd_v  = 0; wb_fwd_we  = 0; wb_fwd_rd  = 0; wb_fwd_data  = 0;
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
      input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3, input logic [6:0] op);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
      input logic [6:0] op);
    return {imm, rd, op};
  endfunction

  logic [31:0] add_x3, add_x7, add_x6, addi_h, beq, slli, addiw, auipc, lui, addi_x6;

  initial begin
    add_x3  = enc_r(7'd0, 5'd2, 5'd1, 3'd0, 5'd3, 7'b0110011);
    add_x7  = enc_r(7'd0, 5'd0, 5'd0, 3'd0, 5'd7, 7'b0110011);
    add_x6  = enc_r(7'd0, 5'd0, 5'd5, 3'd0, 5'd6, 7'b0110011);
    addi_h  = enc_i(12'd1, 5'd1, 3'd0, 5'd1, 7'b0010011);
    beq     = enc_b(13'h1FF8, 5'd2, 5'd1, 3'd0, 7'b1100011);
    slli    = enc_i(12'h028, 5'd2, 3'd1, 5'd1, 7'b0010011);
    addiw   = enc_i(12'd5, 5'd2, 3'd0, 5'd1, 7'b0011011);
    auipc   = enc_u(20'h80000, 5'd1, 7'b0010111);
    lui     = enc_u(20'h00028, 5'd1, 7'b0110111);
    addi_x6 = enc_i(12'd5, 5'd0, 3'd0, 5'd6, 7'b0010011);

    // Reset
    rst = 1; de_v = 0; flush = 0; exe_ready = 1; de_ir = 0; de_npc = 0;
    rs1_data = 0; rs2_data = 0; clr_fwd();
    tick();
    chk("rst_a_v", 64'(a_exe_v), 64'd0);
    chk("rst_a_cnt", 64'(a_cnt), 64'd0);
    chk("rst_a_op1", a_op1, 64'd0);
    chk("rst_b_v", 64'(b_exe_v), 64'd0);
    rst = 0;

    // ADD x3,x1,x2: EXE beats MEM for x1, WB supplies x2
    de_v = 1; de_ir = add_x3; de_npc = 64'h200; rs1_data = 111; rs2_data = 222;
    exe_fwd_v = 1; exe_fwd_we = 1; exe_fwd_rd = 1; exe_fwd_data = 5;
    mem_fwd_v = 1; mem_fwd_we = 1; mem_fwd_rd = 1; mem_fwd_data = 7;
    wb_fwd_v = 1; wb_fwd_we = 1; wb_fwd_rd = 2; wb_fwd_data = 9;
    #1;
    chk("add_ready", 64'(a_de_ready), 64'd1);
    chk("add_rs1a", 64'(a_rs1_addr), 64'd1);
    chk("add_rs2a", 64'(a_rs2_addr), 64'd2);
    chk("add_b_rs2a", 64'(b_rs2_addr), 64'd2);
    tick();
    chk("add_v", 64'(a_exe_v), 64'd1);
    chk("add_ir", 64'(a_exe_ir), 64'(add_x3));
    chk("add_npc", a_npc, 64'h200);
    chk("add_op1", a_op1, 64'd5);
    chk("add_op2", a_op2, 64'd9);
    chk("add_sd", a_sd, 64'd9);
    chk("add_b_op1", 64'(b_op1), 64'd5);
    chk("add_b_npc", 64'(b_npc), 64'h200);

    // x0 operands ignore a loading producer that names RD=0
    clr_fwd(); de_ir = add_x7; rs1_data = 55; rs2_data = 66;
    exe_fwd_v = 1; exe_fwd_we = 1; exe_fwd_ld = 1; exe_fwd_rd = 0; exe_fwd_data = 123;
    #1;
    chk("x0_ready", 64'(a_de_ready), 64'd1);
    tick();
    chk("x0_op1", a_op1, 64'd0);
    chk("x0_op2", a_op2, 64'd0);
    chk("x0_cnt", 64'(a_cnt), 64'd0);

    // Load-use: LD x5 in EXE, then ADD x6,x5,x0
    clr_fwd(); de_ir = add_x6; rs1_data = 0;
    exe_fwd_v = 1; exe_fwd_we = 1; exe_fwd_ld = 1; exe_fwd_rd = 5; exe_fwd_data = 64'hdead;
    #1;
    chk("lu1_a_ready", 64'(a_de_ready), 64'd0);
    chk("lu1_b_ready", 64'(b_de_ready), 64'd0);
    tick();
    chk("lu1_a_v", 64'(a_exe_v), 64'd0);
    chk("lu1_a_cnt", 64'(a_cnt), 64'd1);
    chk("lu1_b_cnt", 64'(b_cnt), 64'd1);
    clr_fwd(); mem_fwd_v = 1; mem_fwd_we = 1; mem_fwd_ld = 1; mem_fwd_rd = 5; mem_fwd_data = 64'h77;
    #1;
    chk("lu2_a_ready", 64'(a_de_ready), 64'd0);
    chk("lu2_b_ready", 64'(b_de_ready), 64'd1);
    tick();
    chk("lu2_a_v", 64'(a_exe_v), 64'd0);
    chk("lu2_a_cnt", 64'(a_cnt), 64'd2);
    chk("lu2_b_v", 64'(b_exe_v), 64'd1);
    chk("lu2_b_op1", 64'(b_op1), 64'h77);
    clr_fwd(); wb_fwd_v = 1; wb_fwd_we = 1; wb_fwd_rd = 5; wb_fwd_data = 64'h77;
    #1;
    chk("lu3_a_ready", 64'(a_de_ready), 64'd1);
    tick();
    chk("lu3_a_v", 64'(a_exe_v), 64'd1);
    chk("lu3_a_op1", a_op1, 64'h77);
    chk("lu3_a_cnt", 64'(a_cnt), 64'd2);

    // Back-pressure hold, then flush
    clr_fwd(); exe_ready = 0; de_ir = addi_h; rs1_data = 64'h999;
    #1;
    chk("hold_ready", 64'(a_de_ready), 64'd0);
    tick();
    chk("hold_v", 64'(a_exe_v), 64'd1);
    chk("hold_ir", 64'(a_exe_ir), 64'(add_x6));
    chk("hold_op1", a_op1, 64'h77);
    flush = 1;
    #1;
    chk("flush_ready", 64'(a_de_ready), 64'd0);
    tick();
    chk("flush_a_v", 64'(a_exe_v), 64'd0);
    chk("flush_b_v", 64'(b_exe_v), 64'd0);
    chk("flush_ir", 64'(a_exe_ir), 64'(add_x6));
    flush = 0; de_v = 0;
    tick();
    chk("idle_v", 64'(a_exe_v), 64'd0);
    chk("idle_cnt", 64'(a_cnt), 64'd2);

    // Immediates
    exe_ready = 1; de_v = 1; rs1_data = 0; rs2_data = 64'h1234;
    de_ir = beq;
    tick();
    chk("beq_imm", a_imm, 64'hFFFF_FFFF_FFFF_FFF8);
    chk("beq_op2", a_op2, 64'h1234);
    chk("beq_b_imm", 64'(b_imm), 64'hFFFF_FFF8);
    chk("beq_b_sd", 64'(b_sd), 64'h1234);
    de_ir = slli;
    tick();
    chk("slli_imm", a_imm, 64'd40);
    chk("slli_op2", a_op2, 64'd40);
    chk("slli_b_imm", 64'(b_imm), 64'd8);
    de_ir = addiw;
    tick();
    chk("addiw_a_ill", 64'(a_ill), 64'd0);
    chk("addiw_a_imm", a_imm, 64'd5);
    chk("addiw_b_ill", 64'(b_ill), 64'd1);
    de_ir = auipc; de_npc = 64'h1004;
    tick();
    chk("auipc_op1", a_op1, 64'h1000);
    chk("auipc_imm", a_imm, 64'hFFFF_FFFF_8000_0000);
    chk("auipc_b_op1", 64'(b_op1), 64'h1000);
    chk("auipc_b_imm", 64'(b_imm), 64'h8000_0000);
    de_ir = 32'h0000_0073;
    tick();
    chk("ecall_a", 64'(a_ecall), 64'd1);
    chk("ecall_b", 64'(b_ecall), 64'd1);
    chk("ecall_ill", 64'(a_ill), 64'd0);
    de_ir = 32'h0000_007F;
    tick();
    chk("bad_a_ill", 64'(a_ill), 64'd1);
    chk("bad_b_ill", 64'(b_ill), 64'd1);
    chk("bad_ecall", 64'(a_ecall), 64'd0);
    chk("bad_b_ir", 64'(b_exe_ir), 64'h0000_007F);

    // Loading producer only blocks operands the opcode reads
    exe_fwd_v = 1; exe_fwd_we = 1; exe_fwd_ld = 1; exe_fwd_rd = 5;
    de_ir = addi_x6;
    #1;
    chk("addi_rs2a", 64'(a_rs2_addr), 64'd5);
    chk("addi_ready", 64'(a_de_ready), 64'd1);
    tick();
    chk("addi_v", 64'(a_exe_v), 64'd1);
    chk("addi_op2", a_op2, 64'd5);
    de_ir = lui;
    #1;
    chk("lui_rs1a", 64'(a_rs1_addr), 64'd5);
    chk("lui_ready", 64'(a_de_ready), 64'd1);
    tick();
    chk("lui_op1", a_op1, 64'd0);
    chk("lui_imm", a_imm, 64'h28000);
    chk("lui_cnt", 64'(a_cnt), 64'd2);

    // Saturation: three more bubbles (five total) on a 2-bit counter
    de_ir = add_x6;
    tick();
    chk("sat1_a_cnt", 64'(a_cnt), 64'd3);
    chk("sat1_a_v", 64'(a_exe_v), 64'd0);
    tick();
    chk("sat2_a_cnt", 64'(a_cnt), 64'd3);
    tick();
    chk("sat3_a_cnt", 64'(a_cnt), 64'd3);
    chk("sat3_b_cnt", 64'(b_cnt), 64'd4);
    flush = 1;
    tick();
    chk("flush_hz_b_cnt", 64'(b_cnt), 64'd4);
    flush = 0;

    // Reset while stalled drops the instruction and clears the counter
    rst = 1;
    tick();
    chk("rst2_a_cnt", 64'(a_cnt), 64'd0);
    chk("rst2_b_cnt", 64'(b_cnt), 64'd0);
    chk("rst2_a_v", 64'(a_exe_v), 64'd0);
    chk("rst2_a_ir", 64'(a_exe_ir), 64'd0);
    rst = 0; de_v = 0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
